mestre_memoria_dados: RTL

Initiator-side controller for the 16×16 synchronous data memory (`memoria_dados`). It drives the memory's `wren`, `Address` and `Din` pins and samples its registered `Q` output, hiding the memory's one-cycle read latency behind a start/busy/done handshake. It sits between the processor datapath (loads and stores) and the memory. It also offers block fill and block copy for initialization and test.

---
 rtl/mestre_memoria_dados.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mestre_memoria_dados.sv
// -----------------------------------------------------------------------------
// mestre_memoria_dados
//
// Initiator-side controller for the 16x16 synchronous data memory
// (memoria_dados). It turns single commands into memory pin activity and hides
// the memory's one-cycle registered read latency behind a start/busy/done
// handshake. Commands: LOAD, STORE, block FILL and block COPY.
//
// Ports
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   start               command strobe, accepted only while busy = 0
//   op                  00 LOAD, 01 STORE, 10 COPY, 11 FILL
//   addr                LOAD/STORE address, COPY source base, FILL base
//   addr2               COPY destination base
//   len                 word count minus one for COPY and FILL
//   wdata               STORE data and FILL value
//   busy, done          handshake: busy from acceptance to done, done one pulse
//   rdata               last word read (LOAD or COPY), held otherwise
//   mem_wren, mem_address, mem_din   drive the memory's wren/Address/Din
//   mem_q               memory's registered Q output
//
// All outputs are registered. mem_wren is always low on the edge where the
// FSM samples mem_q, so the memory's write-through Q never corrupts a read.
// -----------------------------------------------------------------------------
module mestre_memoria_dados (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [3:0]  addr,
  input  logic [3:0]  addr2,
  input  logic [3:0]  len,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        mem_wren,
  output logic [3:0]  mem_address,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_q
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_COPY  = 2'b10,
    OP_FILL  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE, LD_WAIT, LD_CAP, ST_WR, FILL_WR, CP_RD, CP_CAP, CP_WR
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [3:0]  src, src_nx;
  logic [3:0]  dst, dst_nx;
  logic        busy_nx, done_nx, wren_nx;
  logic [15:0] rdata_nx, din_nx;
  logic [3:0]  address_nx;

  // Next-state and next-output logic. The command fields are captured
  // directly into the address/data/pointer registers at acceptance, so no
  // separate copy of op/addr/wdata is kept.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_nx   = state;
    cnt_nx     = cnt;
    src_nx     = src;
    dst_nx     = dst;
    busy_nx    = busy;
    done_nx    = 1'b0;
    wren_nx    = mem_wren;
    rdata_nx   = rdata;
    din_nx     = mem_din;
    address_nx = mem_address;

    unique case (state)
      IDLE: begin
        if (start) begin
          busy_nx    = 1'b1;
          address_nx = addr;
          unique case (op_t'(op))
            OP_LOAD: begin
              wren_nx  = 1'b0;
              state_nx = LD_WAIT;
            end
            OP_STORE: begin
              wren_nx  = 1'b1;
              din_nx   = wdata;
              state_nx = ST_WR;
            end
            OP_FILL: begin
              wren_nx  = 1'b1;
              din_nx   = wdata;
              cnt_nx   = len;
              state_nx = FILL_WR;
            end
            OP_COPY: begin
              wren_nx  = 1'b0;
              src_nx   = addr;
              dst_nx   = addr2;
              cnt_nx   = len;
              state_nx = CP_RD;
            end
          endcase
        end
      end

      // Memory registers Q on this edge.
      LD_WAIT: state_nx = LD_CAP;

      LD_CAP: begin
        rdata_nx = mem_q;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end

      ST_WR: begin
        wren_nx  = 1'b0;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end

      // The memory writes the current word on every edge spent here.
      FILL_WR: begin
        if (cnt == 4'd0) begin
          wren_nx  = 1'b0;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          address_nx = mem_address + 4'd1;
          cnt_nx     = cnt - 4'd1;
        end
      end

      CP_RD: state_nx = CP_CAP;

      // mem_q holds the source word; turn it around as the write data.
      CP_CAP: begin
        wren_nx    = 1'b1;
        address_nx = dst;
        din_nx     = mem_q;
        rdata_nx   = mem_q;
        state_nx   = CP_WR;
      end

      // Write completes here before the next source read starts, which
      // gives strict ascending semantics for overlapping regions.
      CP_WR: begin
        wren_nx = 1'b0;
        if (cnt == 4'd0) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          src_nx     = src + 4'd1;
          dst_nx     = dst + 4'd1;
          cnt_nx     = cnt - 4'd1;
          address_nx = src + 4'd1;
          state_nx   = CP_RD;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // Reset has priority over any command on the same edge.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      src         <= '0;
      dst         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata       <= '0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_din     <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      src         <= src_nx;
      dst         <= dst_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      rdata       <= rdata_nx;
      mem_wren    <= wren_nx;
      mem_address <= address_nx;
      mem_din     <= din_nx;
    end
  end

endmodule
